// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg : shared modes, exception kinds, vector offsets and sequencer states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package exc_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    // Bit positions inside exc_req / exc_ack
    localparam logic [2:0] EXC_SVC  = 3'd0;
    localparam logic [2:0] EXC_UND  = 3'd1;
    localparam logic [2:0] EXC_PABT = 3'd2;
    localparam logic [2:0] EXC_DABT = 3'd3;
    localparam logic [2:0] EXC_IRQ  = 3'd4;
    localparam logic [2:0] EXC_FIQ  = 3'd5;

    localparam logic [7:0] VEC_UND  = 8'h04;
    localparam logic [7:0] VEC_SVC  = 8'h08;
    localparam logic [7:0] VEC_PABT = 8'h0C;
    localparam logic [7:0] VEC_DABT = 8'h10;
    localparam logic [7:0] VEC_IRQ  = 8'h18;
    localparam logic [7:0] VEC_FIQ  = 8'h1C;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SWITCH  = 3'd1,
        SAVE_LR = 3'd2,
        VECTOR  = 3'd3,
        RET     = 3'd4
    } seq_state_t;

    // Modes a return is allowed to restore
    function automatic logic mode_legal(input logic [4:0] m);
        logic ok;
        case (m[3:0])
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
            4'b0111, 4'b1010, 4'b1011, 4'b1111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return m[4] & ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc : masks IRQ/FIQ and picks the highest-priority exception
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [5:0] req,
    input  logic       cpsr_i,
    input  logic       cpsr_f,
    output logic       valid,
    output logic [2:0] kind,
    output logic [4:0] mode,
    output logic [7:0] vec_ofs
);

    logic [5:0] masked;

    always_comb begin
        masked  = req & ~{cpsr_f, cpsr_i, 4'b0000};
        valid   = |masked;
        kind    = EXC_SVC;
        mode    = MODE_SVC;
        vec_ofs = VEC_SVC;
        // dabt outranks fiq so a faulting load is never lost behind an interrupt
        if (masked[EXC_DABT]) begin
            kind = EXC_DABT; mode = MODE_ABT; vec_ofs = VEC_DABT;
        end else if (masked[EXC_FIQ]) begin
            kind = EXC_FIQ;  mode = MODE_FIQ; vec_ofs = VEC_FIQ;
        end else if (masked[EXC_IRQ]) begin
            kind = EXC_IRQ;  mode = MODE_IRQ; vec_ofs = VEC_IRQ;
        end else if (masked[EXC_PABT]) begin
            kind = EXC_PABT; mode = MODE_ABT; vec_ofs = VEC_PABT;
        end else if (masked[EXC_UND]) begin
            kind = EXC_UND;  mode = MODE_UND; vec_ofs = VEC_UND;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer : drives banked register file through exception entry
// and return. Optional EXC_HIVEC_EN adds the hivec input (high vectors).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exception_sequencer
    import exc_pkg::*;
#(
    parameter logic [4:0]  RESET_MODE  = 5'b10011,
    parameter logic [31:0] DABT_LR_OFS = 32'd8,
    parameter logic [31:0] EXC_LR_OFS  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef EXC_HIVEC_EN
    input  logic        hivec,
`endif
    input  logic [5:0]  exc_req,
    input  logic        cpsr_i,
    input  logic        cpsr_f,
    input  logic [31:0] cur_pc,
    input  logic        ret_req,
    input  logic [4:0]  ret_mode,
    input  logic [31:0] ret_pc,
    output logic [4:0]  mode_out,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data,
    output logic        write_reg,
    output logic        write_pc,
    output logic [31:0] pc_data,
    output logic        busy,
    output logic [5:0]  exc_ack,
    output logic        ret_ack,
    output logic        ret_err
);

    seq_state_t  state;
    logic [2:0]  kind_q;
    logic [31:0] lr_q;
    logic [31:0] vec_q;

    logic        enc_valid;
    logic [2:0]  enc_kind;
    logic [4:0]  enc_mode;
    logic [7:0]  enc_ofs;
    logic [31:0] vec_base;

    exc_prio_enc u_prio (
        .req     (exc_req),
        .cpsr_i  (cpsr_i),
        .cpsr_f  (cpsr_f),
        .valid   (enc_valid),
        .kind    (enc_kind),
        .mode    (enc_mode),
        .vec_ofs (enc_ofs)
    );

`ifdef EXC_HIVEC_EN
    assign vec_base = hivec ? 32'hFFFF_0000 : 32'h0000_0000;
`else
    assign vec_base = 32'h0000_0000;
`endif

    // Outputs are set on entry to a state so each strobe is valid for the
    // whole cycle the sequencer spends in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kind_q    <= EXC_SVC;
            lr_q      <= '0;
            vec_q     <= '0;
            mode_out  <= RESET_MODE;
            w_addr    <= '0;
            w_data    <= '0;
            pc_data   <= '0;
            write_reg <= 1'b0;
            write_pc  <= 1'b0;
            busy      <= 1'b0;
            exc_ack   <= '0;
            ret_ack   <= 1'b0;
            ret_err   <= 1'b0;
        end else begin
            write_reg <= 1'b0;
            write_pc  <= 1'b0;
            exc_ack   <= '0;
            ret_ack   <= 1'b0;
            ret_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        kind_q   <= enc_kind;
                        lr_q     <= cur_pc + ((enc_kind == EXC_DABT) ? DABT_LR_OFS : EXC_LR_OFS);
                        vec_q    <= vec_base + {24'd0, enc_ofs};
                        mode_out <= enc_mode;
                        busy     <= 1'b1;
                        state    <= SWITCH;
                    end else if (ret_req) begin
                        busy  <= 1'b1;
                        state <= RET;
                        if (mode_legal(ret_mode)) begin
                            mode_out <= ret_mode;
                            write_pc <= 1'b1;
                            pc_data  <= ret_pc;
                            ret_ack  <= 1'b1;
                        end else begin
                            ret_err  <= 1'b1;
                        end
                    end
                end
                SWITCH: begin
                    write_reg <= 1'b1;
                    w_addr    <= 4'd14;
                    w_data    <= lr_q;
                    state     <= SAVE_LR;
                end
                SAVE_LR: begin
                    write_pc <= 1'b1;
                    pc_data  <= vec_q;
                    exc_ack  <= 6'b000001 << kind_q;
                    state    <= VECTOR;
                end
                VECTOR, RET: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
